// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the tick generator.
package tick_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DIV_W_DEF = 8;
   localparam int CNT_W_DEF = 3;

   // A divisor of 0 behaves as divide-by-1.
   function automatic logic [31:0] div_norm(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Period counter: pre counts enabled cycles, div_q is the divisor latched per period.
module tick_prescaler
   import tick_gen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tc,
   output logic             pend
);

   logic [DIV_W-1:0] pre;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_n;

   assign div_n = DIV_W'(div_norm(32'(div)));
   assign tc    = en && (pre == (div_q - DIV_W'(1)));
   assign pend  = (pre != '0);

   // div_q only reloads at a period boundary so a new divisor never cuts a period short
   always_ff @(posedge clk) begin
      if (rst) begin
         pre   <= '0;
         div_q <= DIV_W'(1);
      end else if (clr) begin
         pre   <= '0;
         div_q <= div_n;
      end else if (en) begin
         if (tc) begin
            pre   <= '0;
            div_q <= div_n;
         end else begin
            pre <= pre + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick generator with slow tick counter.
// Define TICK_GEN_ONESHOT_EN to enable one-shot mode (mode/start); otherwise free-run only.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             mode,
   input  logic             start,
   output logic             tick,
   output logic [CNT_W-1:0] slow_cnt,
   output logic             wrap,
   output logic             busy
);

   state_t           state;
   logic             mode_q;
   logic             go;
   logic             os_req;
   logic             tc;
   logic             pend;
   logic             last;
   logic [CNT_W-1:0] cnt_nxt;

`ifdef TICK_GEN_ONESHOT_EN
   assign os_req = mode;
   assign go     = (state == IDLE) && (mode ? start : en);
`else
   logic unused_cfg;
   assign unused_cfg = &{1'b0, mode, start};
   assign os_req     = 1'b0;
   assign go         = (state == IDLE) && en;
`endif

   tick_prescaler #(.DIV_W(DIV_W)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .clr  (go),
      .en   ((state == RUN) && en),
      .div  (div),
      .tc   (tc),
      .pend (pend)
   );

   assign cnt_nxt = slow_cnt + CNT_W'(1);
   assign last    = tc && mode_q && (cnt_nxt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mode_q   <= 1'b0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
         busy     <= 1'b0;
         slow_cnt <= '0;
      end else begin
         tick <= tc;
         wrap <= tc && !mode_q && (slow_cnt == '1);
         if (tc)
            slow_cnt <= cnt_nxt;
         case (state)
            IDLE: begin
               if (go) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  mode_q <= os_req;
                  if (os_req)
                     slow_cnt <= '0;
               end
            end
            RUN: begin
               // free-run only parks at a period boundary; mid-period en=0 is a pause
               if (last || (!mode_q && !en && !pend)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
